// File: rtl/uart_boot_loader_ctrl.sv
// rtl/uart_boot_loader_ctrl.sv - UART boot loader: header word count, word assembly, program memory writes, ack byte, core release
// Outputs are masked while rst is high so a reset aborts any pending write or ack at once.
module uart_boot_loader_ctrl #(
  parameter int          ADDR_W   = 15,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              core_start,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_ACK   = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       hdr_q, hdr_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              err_q, err_d;

  logic [31:0]       hdr_word;
  logic [31:0]       asm_word;

  // Bytes arrive little-endian, so each new byte enters at the top and shifts down.
  assign hdr_word = {rx_data, hdr_q[31:8]};
  assign asm_word = {rx_data, asm_q[31:8]};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    hdr_d   = hdr_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_HDR: begin
        if (rx_valid) begin
          hdr_d  = hdr_word;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (hdr_word == 32'd0) begin
              state_d = S_ACK;
            end else if ({1'b0, hdr_word} > MAX_N) begin
              err_d = 1'b1;
            end else begin
              state_d = S_DATA;
              addr_d  = '0;
              rem_d   = hdr_word[ADDR_W:0];
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d  = asm_word;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // A byte landing here has nowhere to go: drop it and flag the overrun.
        if (rx_valid) begin
          err_d = 1'b1;
        end
        if (mem_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = (rem_q == (ADDR_W+1)'(1)) ? S_ACK : S_DATA;
        end
      end
      S_ACK: begin
        if (tx_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      bcnt_q  <= '0;
      hdr_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      hdr_q   <= hdr_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign mem_we     = !rst && (state_q == S_WRITE);
  assign mem_addr   = rst ? '0 : addr_q;
  assign mem_wdata  = rst ? 32'd0 : asm_q;
  assign tx_valid   = !rst && (state_q == S_ACK);
  assign tx_data    = (!rst && (state_q == S_ACK)) ? ACK_BYTE : 8'd0;
  assign core_start = !rst && (state_q == S_RUN);
  assign busy       = !rst && (((state_q == S_HDR) && (bcnt_q != 2'd0)) ||
                               (state_q == S_DATA) || (state_q == S_WRITE) ||
                               (state_q == S_ACK));
  assign err        = !rst && err_q;

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// tb/tb_uart_boot_loader_ctrl.sv - table-driven bench for uart_boot_loader_ctrl at ADDR_W=4
module tb_uart_boot_loader_ctrl;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic              core_start;
  logic              busy;
  logic              err;

  uart_boot_loader_ctrl #(.ADDR_W(ADDR_W), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .core_start(core_start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory / transmitter models, driven and sampled on the falling edge.
  int          stall_cfg = 0;
  int          tx_stall_cfg = 0;
  int          we_run = 0;
  int          tx_run = 0;
  int          wr_cnt = 0;
  int          tx_cnt = 0;
  int          unstable = 0;
  int          we_len_last = 0;
  logic [31:0] mem_model [0:15];
  logic [3:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [7:0]  tx_last = '0;
  logic [3:0]  a0 = '0;
  logic [31:0] d0 = '0;

  always @(negedge clk) begin
    if (mem_we) begin
      mem_ready = (we_run >= stall_cfg);
      if (we_run == 0) begin
        a0 = mem_addr;
        d0 = mem_wdata;
      end else if (mem_addr != a0 || mem_wdata != d0) begin
        unstable++;
      end
      we_run++;
      if (mem_ready) begin
        mem_model[mem_addr] = mem_wdata;
        wr_cnt++;
        last_addr   = mem_addr;
        last_data   = mem_wdata;
        we_len_last = we_run;
      end
    end else begin
      we_run    = 0;
      mem_ready = 1'b0;
    end
    if (tx_valid) begin
      tx_ready = (tx_run >= tx_stall_cfg);
      tx_run++;
      if (tx_ready) begin
        tx_cnt++;
        tx_last = tx_data;
      end
    end else begin
      tx_run   = 0;
      tx_ready = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", {15'd0, mem_we, tx_valid, core_start, busy, err, mem_addr, mem_wdata, tx_data}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8], 0);
  endtask

  task automatic wait_write_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (!mem_we) break;
      @(posedge clk); #1;
    end
    check(name, {63'd0, mem_we}, 64'd0);
  endtask

  task automatic wait_core(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (core_start) break;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit          do_reset;
    logic [31:0] n;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] step;
    int          stall;
    int          tx_stall;
    int          exp_writes;
    bit          exp_err;
    bit          exp_run;
    logic [3:0]  exp_last_addr;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base_wr, base_tx, base_uns;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr, base_tx, base_uns;
    vecs[0] = '{1'b1, 32'd2,  2,  32'h44332211, 32'h44444444, 0, 0, 2,  1'b0, 1'b1, 4'd1,  32'h88776655};
    vecs[1] = '{1'b1, 32'd0,  0,  32'h0,        32'h0,        0, 0, 0,  1'b0, 1'b1, 4'd0,  32'h0};
    vecs[2] = '{1'b1, 32'd1,  1,  32'hDEADBEEF, 32'h0,        5, 3, 1,  1'b0, 1'b1, 4'd0,  32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'd17, 0,  32'h0,        32'h0,        0, 0, 0,  1'b1, 1'b0, 4'd0,  32'h0};
    vecs[4] = '{1'b0, 32'd1,  1,  32'h12345678, 32'h0,        0, 0, 1,  1'b1, 1'b1, 4'd0,  32'h12345678};
    vecs[5] = '{1'b1, 32'd16, 16, 32'h00000100, 32'h1,        1, 2, 16, 1'b0, 1'b1, 4'd15, 32'h0000010F};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int v = 0; v < 6; v++) begin
      stall_cfg    = vecs[v].stall;
      tx_stall_cfg = vecs[v].tx_stall;
      if (vecs[v].do_reset) do_reset();
      base_wr  = wr_cnt;
      base_tx  = tx_cnt;
      base_uns = unstable;
      send_word(vecs[v].n);
      for (int k = 0; k < vecs[v].nwords; k++) begin
        send_word(vecs[v].w0 + vecs[v].step * k);
        wait_write_done($sformatf("v%0d_write_done", v));
      end
      if (vecs[v].exp_run) wait_core(100);
      else repeat (4) begin @(posedge clk); #1; end
      check($sformatf("v%0d_writes", v), 64'(wr_cnt - base_wr), 64'(vecs[v].exp_writes));
      check($sformatf("v%0d_err", v), {63'd0, err}, {63'd0, vecs[v].exp_err});
      check($sformatf("v%0d_core_start", v), {63'd0, core_start}, {63'd0, vecs[v].exp_run});
      check($sformatf("v%0d_tx_count", v), 64'(tx_cnt - base_tx), {63'd0, vecs[v].exp_run});
      check($sformatf("v%0d_busy", v), {63'd0, busy}, 64'd0);
      if (vecs[v].exp_run) check($sformatf("v%0d_tx_byte", v), {56'd0, tx_last}, 64'hAA);
      if (vecs[v].exp_writes > 0) begin
        check($sformatf("v%0d_mem0", v), {32'd0, mem_model[0]}, {32'd0, vecs[v].w0});
        check($sformatf("v%0d_last_addr", v), {60'd0, last_addr}, {60'd0, vecs[v].exp_last_addr});
        check($sformatf("v%0d_last_data", v), {32'd0, last_data}, {32'd0, vecs[v].exp_last});
        check($sformatf("v%0d_we_len", v), 64'(we_len_last), 64'(vecs[v].stall + 1));
        check($sformatf("v%0d_stable", v), 64'(unstable - base_uns), 64'd0);
      end
    end

    // RUN ignores further bytes
    base_wr = wr_cnt;
    send_word(32'h01020304);
    send_word(32'h05060708);
    repeat (4) begin @(posedge clk); #1; end
    check("run_no_writes", 64'(wr_cnt - base_wr), 64'd0);
    check("run_no_err", {63'd0, err}, 64'd0);
    check("run_core_start", {63'd0, core_start}, 64'd1);

    // Overrun during WRITE: byte dropped, load completes, err sticky
    stall_cfg = 3; tx_stall_cfg = 0;
    do_reset();
    base_wr = wr_cnt; base_tx = tx_cnt;
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    check("ovr_in_write", {63'd0, mem_we}, 64'd1);
    send_byte(8'hEE, 0);
    wait_write_done("ovr_write_done");
    wait_core(100);
    check("ovr_writes", 64'(wr_cnt - base_wr), 64'd1);
    check("ovr_mem0", {32'd0, mem_model[0]}, 64'hCAFEF00D);
    check("ovr_core_start", {63'd0, core_start}, 64'd1);
    check("ovr_tx", 64'(tx_cnt - base_tx), 64'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("ovr_err_sticky", {63'd0, err}, 64'd1);

    // Reset in DATA after 2 bytes, then a fresh load
    stall_cfg = 0;
    do_reset();
    base_wr = wr_cnt;
    send_word(32'd1);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    check("mid_data_busy", {63'd0, busy}, 64'd1);
    do_reset();
    send_word(32'd1);
    send_word(32'h0BADC0DE);
    wait_write_done("fresh_write_done");
    wait_core(100);
    check("fresh_writes", 64'(wr_cnt - base_wr), 64'd1);
    check("fresh_addr", {60'd0, last_addr}, 64'd0);
    check("fresh_data", {32'd0, last_data}, 64'h0BADC0DE);
    check("fresh_err", {63'd0, err}, 64'd0);

    // Reset mid-WRITE with mem_ready held low
    stall_cfg = 1000;
    do_reset();
    base_wr = wr_cnt;
    send_word(32'd1);
    send_word(32'h55AA55AA);
    repeat (3) begin @(posedge clk); #1; end
    check("stuck_write_we", {63'd0, mem_we}, 64'd1);
    do_reset();
    repeat (5) begin @(posedge clk); #1; end
    check("abort_write_count", 64'(wr_cnt - base_wr), 64'd0);
    check("abort_write_we", {63'd0, mem_we}, 64'd0);
    check("abort_write_busy", {63'd0, busy}, 64'd0);

    // Reset mid-ACK with tx_ready held low; rx bytes in ACK raise no err
    stall_cfg = 0; tx_stall_cfg = 1000;
    do_reset();
    base_tx = tx_cnt;
    send_word(32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("ack_tx_valid", {63'd0, tx_valid}, 64'd1);
    check("ack_tx_data", {56'd0, tx_data}, 64'hAA);
    check("ack_busy", {63'd0, busy}, 64'd1);
    send_byte(8'h5A, 1);
    check("ack_rx_no_err", {63'd0, err}, 64'd0);
    do_reset();
    repeat (5) begin @(posedge clk); #1; end
    check("abort_ack_tx", 64'(tx_cnt - base_tx), 64'd0);
    check("abort_ack_valid", {63'd0, tx_valid}, 64'd0);
    check("abort_ack_core", {63'd0, core_start}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader_ctrl.md
UART_BOOT_LOADER_CTRL -- requirements
Module: uart_boot_loader_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 15: word-address width of the program memory write port.
REQ-002 SHALL provide parameter ACK_BYTE, default 8'hAA: byte sent to the host after a load completes.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle pulse when the UART receiver delivers a byte.
REQ-006 SHALL have port rx_data, input, 8: received byte, valid when rx_valid=1.
REQ-007 SHALL have port mem_we, output, 1: program-memory write request.
REQ-008 SHALL have port mem_addr, output, ADDR_W: word address of the write.
REQ-009 SHALL have port mem_wdata, output, 32: write data.
REQ-010 SHALL have port mem_ready, input, 1: memory accepts the write on a cycle where mem_we=1 and mem_ready=1.
REQ-011 SHALL have port tx_valid, output, 1: byte offered to the UART transmitter.
REQ-012 SHALL have port tx_data, output, 8: transmit byte.
REQ-013 SHALL have port tx_ready, input, 1: transmitter accepts on a cycle where tx_valid=1 and tx_ready=1.
REQ-014 SHALL have port core_start, output, 1: level; releases the VLIW core from hold.
REQ-015 SHALL have port busy, output, 1: high in HDR-after-first-byte, DATA, WRITE and ACK.
REQ-016 SHALL have port err, output, 1: sticky error flag.

Function
REQ-017 SHALL implement states HDR, DATA, WRITE, ACK and RUN, with HDR entered on reset.
REQ-018 In HDR, SHALL collect 4 bytes little-endian (first byte = bits 7:0) into the word count N.
REQ-019 On the 4th header byte, SHALL go to ACK if N=0, set err and return to HDR (header counter cleared) if N > 2^ADDR_W, and otherwise go to DATA with the write address at 0.
REQ-020 In DATA, SHALL shift bytes little-endian into a 32-bit assembly register.
REQ-021 On the 4th data byte, SHALL go to WRITE the next cycle, with mem_we=1, mem_wdata = the assembled word and mem_addr = the current address.
REQ-022 In WRITE, SHALL hold mem_we, mem_addr and mem_wdata stable until a cycle with mem_ready=1.
REQ-023 On the accepting cycle, SHALL deassert mem_we the next cycle, increment the address and decrement the remaining count.
REQ-024 After the accepting cycle, SHALL go to ACK if the remaining count reaches 0, and otherwise return to DATA.
REQ-025 If mem_ready=1 in the first WRITE cycle, the write SHALL complete in a single cycle.
REQ-026 If rx_valid=1 while in WRITE, SHALL drop the byte and set err (overrun), and SHALL still complete the pending write normally.
REQ-027 In ACK, SHALL drive tx_valid=1 and tx_data=ACK_BYTE until tx_ready=1, then go to RUN the next cycle.
REQ-028 In ACK, SHALL ignore rx bytes and SHALL NOT set err for them.
REQ-029 In RUN, SHALL hold core_start=1 until reset, and SHALL ignore all rx bytes (no err, no writes).
REQ-030 Address arithmetic SHALL be ADDR_W bits; with N = 2^ADDR_W the last write SHALL go to address 2^ADDR_W-1, and the address wrap to 0 SHALL be unobservable.
REQ-031 When rx_valid coincides with the 4th-byte transition, SHALL count that byte as the 4th byte; the next byte SHALL be the 1st byte of the following word.
REQ-032 The word count register SHALL be 32 bits; the remaining counter SHALL be ADDR_W+1 bits.

Reset
REQ-033 While rst=1 at a clock edge, the next state SHALL be HDR, with all byte counters, address and remaining count = 0.
REQ-034 While rst=1 at a clock edge, mem_we, tx_valid, core_start, busy and err SHALL all be 0, and mem_addr, mem_wdata and tx_data SHALL all be 0.
REQ-035 Reset asserted in any state, including mid-WRITE with mem_ready=0 or mid-ACK, SHALL abort immediately with no further memory write or tx byte.

Verification
REQ-036 Bytes 02 00 00 00, 11 22 33 44, 55 66 77 88 with mem_ready=1 and tx_ready=1 -> writes {addr0=0x44332211, addr1=0x88776655}, then one tx byte 0xAA, then core_start=1 and err=0.
REQ-037 Header 00 00 00 00 -> no mem_we, tx 0xAA, then core_start=1.
REQ-038 N=1 with mem_ready held 0 for 5 cycles -> mem_we high 6 cycles with constant addr/data, exactly one accepted write.
REQ-039 N=1 with a byte arriving mid-WRITE -> err=1, that byte absent from memory, the load still completes, and err stays 1 until reset.
REQ-040 ADDR_W=4, header N=17 -> err=1, state back at HDR; a following valid N=1 load succeeds.
REQ-041 Reset pulsed in DATA after 2 of 4 bytes, then a fresh valid load -> only the fresh data is written, starting at addr 0.
